// File: rtl/pwm_pkg.sv
// Shared types and reset values for the PWM generator.
// The direction enum is used only when PWM_GENERATOR_PHASE_CORRECT_EN is defined.
package pwm_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Replicated across the register width: top resets to all ones, compare to zero.
   localparam logic RST_TOP_BIT     = 1'b1;
   localparam logic RST_COMPARE_BIT = 1'b0;

endpackage

// File: rtl/pwm_counter.sv
// Period counter: edge-aligned up-counter by default, up/down when
// PWM_GENERATOR_PHASE_CORRECT_EN is defined. wrap marks the cycle whose successor is count 0.
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int TOP_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [TOP_WIDTH-1:0] top,
   output logic [TOP_WIDTH-1:0] count,
   output logic                 wrap
);

   localparam logic [TOP_WIDTH-1:0] ONE = TOP_WIDTH'(1);

   logic [TOP_WIDTH-1:0] count_nxt;

`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
   dir_e dir;
   dir_e dir_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
         dir   <= DIR_UP;
      end else begin
         count <= count_nxt;
         dir   <= dir_nxt;
      end
   end

   always_comb begin
      count_nxt = count + ONE;
      dir_nxt   = dir;
      wrap      = 1'b0;
      case (dir)
         DIR_UP: begin
            if (count >= top) begin
               // top of 0 or 1 leaves no down leg, so return straight to 0
               if (top <= ONE) begin
                  wrap      = 1'b1;
                  count_nxt = '0;
               end else begin
                  dir_nxt   = DIR_DOWN;
                  count_nxt = top - ONE;
               end
            end
         end
         DIR_DOWN: begin
            if (count <= ONE) begin
               wrap      = 1'b1;
               count_nxt = '0;
               dir_nxt   = DIR_UP;
            end else begin
               count_nxt = count - ONE;
            end
         end
         default: begin
            wrap      = 1'b1;
            count_nxt = '0;
            dir_nxt   = DIR_UP;
         end
      endcase
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

   // >= rather than == so an out-of-range count still recovers in one cycle
   always_comb begin
      wrap      = (count >= top);
      count_nxt = wrap ? '0 : count + ONE;
   end
`endif

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with double-buffered top/compare that only take effect at period wrap.
// Optional phase-correct (up/down) counting via PWM_GENERATOR_PHASE_CORRECT_EN.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int TOP_WIDTH     = 8,
   parameter int COMPARE_WIDTH = TOP_WIDTH + 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [TOP_WIDTH-1:0]     i_top,
   input  logic                     i_top_valid,
   input  logic [COMPARE_WIDTH-1:0] i_compare,
   input  logic                     i_compare_valid,
   output logic                     o_pwm,
   output logic                     o_period_start
);

   logic [TOP_WIDTH-1:0]     count;
   logic                     wrap;
   logic [TOP_WIDTH-1:0]     active_top;
   logic [TOP_WIDTH-1:0]     pending_top;
   logic                     pending_top_vld;
   logic [COMPARE_WIDTH-1:0] active_compare;
   logic [COMPARE_WIDTH-1:0] pending_compare;
   logic                     pending_compare_vld;
   logic [COMPARE_WIDTH-1:0] count_ext;
   logic                     pwm_p1;
   logic                     period_start_p1;

   pwm_counter #(
      .TOP_WIDTH (TOP_WIDTH)
   ) u_counter (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .top     (active_top),
      .count   (count),
      .wrap    (wrap)
   );

   // Top buffer: a strobe in the wrap cycle bypasses pending and loads directly
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         active_top      <= {TOP_WIDTH{RST_TOP_BIT}};
         pending_top_vld <= 1'b0;
      end else if (wrap) begin
         if (i_top_valid) begin
            active_top <= i_top;
         end else if (pending_top_vld) begin
            active_top <= pending_top;
         end
         pending_top_vld <= 1'b0;
      end else if (i_top_valid) begin
         pending_top_vld <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_top_valid && !wrap) begin
         pending_top <= i_top;
      end
   end

   // Compare buffer: same policy as top, governed by its own flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         active_compare      <= {COMPARE_WIDTH{RST_COMPARE_BIT}};
         pending_compare_vld <= 1'b0;
      end else if (wrap) begin
         if (i_compare_valid) begin
            active_compare <= i_compare;
         end else if (pending_compare_vld) begin
            active_compare <= pending_compare;
         end
         pending_compare_vld <= 1'b0;
      end else if (i_compare_valid) begin
         pending_compare_vld <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_compare_valid && !wrap) begin
         pending_compare <= i_compare;
      end
   end

   assign count_ext = COMPARE_WIDTH'(count);

   // Stage p1: registered waveform and period marker, one cycle behind count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwm_p1          <= 1'b0;
         period_start_p1 <= 1'b0;
      end else begin
         pwm_p1          <= (count_ext < active_compare);
         period_start_p1 <= (count == '0);
      end
   end

   assign o_pwm          = pwm_p1;
   assign o_period_start = period_start_p1;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: period/duty table plus reset and reload corner cases.
// Expected values switch with PWM_GENERATOR_PHASE_CORRECT_EN.
module tb_pwm_generator;

   localparam int TW = 8;
   localparam int CW = 9;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [TW-1:0] i_top;
   logic          i_top_valid;
   logic [CW-1:0] i_compare;
   logic          i_compare_valid;
   logic          o_pwm;
   logic          o_period_start;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      int top;
      int cmp;
      int period;
      int highs;
   } vec_t;

   vec_t vecs[10];

   pwm_generator #(
      .TOP_WIDTH     (TW),
      .COMPARE_WIDTH (CW)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_top           (i_top),
      .i_top_valid     (i_top_valid),
      .i_compare       (i_compare),
      .i_compare_valid (i_compare_valid),
      .o_pwm           (o_pwm),
      .o_period_start  (o_period_start)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic do_reset();
      i_rst_n         = 1'b0;
      i_top_valid     = 1'b0;
      i_compare_valid = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic strobe(input int top, input int cmp, input bit dt, input bit dc);
      i_top           = TW'(top);
      i_compare       = CW'(cmp);
      i_top_valid     = dt;
      i_compare_valid = dc;
      @(negedge i_clk);
      i_top_valid     = 1'b0;
      i_compare_valid = 1'b0;
   endtask

   task automatic wait_ps(input string name);
      for (int i = 0; i < 1200; i++) begin
         @(negedge i_clk);
         if (o_period_start) return;
      end
      check({name, "_timeout"}, 0, 1);
   endtask

   // Starts on a period-start sample; returns on the next one
   task automatic measure(output int n, output int h);
      n = 1;
      h = int'(o_pwm);
      for (int i = 0; i < 1200; i++) begin
         @(negedge i_clk);
         if (o_period_start) return;
         n++;
         h += int'(o_pwm);
      end
      n = -1;
   endtask

   initial begin
      int     n;
      int     h;
      int     p;
      logic [7:0] pat_pwm;
      logic [7:0] pat_ps;

`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
      vecs[0] = '{3, 2, 6, 3};
      vecs[1] = '{3, 0, 6, 0};
      vecs[2] = '{3, 4, 6, 6};
      vecs[3] = '{0, 1, 1, 1};
      vecs[4] = '{0, 0, 1, 0};
      vecs[5] = '{7, 5, 14, 9};
      vecs[6] = '{255, 256, 510, 510};
      vecs[7] = '{255, 0, 510, 0};
      vecs[8] = '{1, 1, 2, 1};
      vecs[9] = '{4, 2, 8, 3};
      p = 6;
`else
      vecs[0] = '{3, 2, 4, 2};
      vecs[1] = '{3, 0, 4, 0};
      vecs[2] = '{3, 4, 4, 4};
      vecs[3] = '{0, 1, 1, 1};
      vecs[4] = '{0, 0, 1, 0};
      vecs[5] = '{7, 5, 8, 5};
      vecs[6] = '{255, 256, 256, 256};
      vecs[7] = '{255, 0, 256, 0};
      vecs[8] = '{1, 1, 2, 1};
      vecs[9] = '{4, 2, 5, 2};
      p = 4;
`endif

      i_top           = '0;
      i_compare       = '0;
      i_top_valid     = 1'b0;
      i_compare_valid = 1'b0;
      i_rst_n         = 1'b0;

      @(negedge i_clk);
      check("rst_pwm", int'(o_pwm), 0);
      check("rst_ps", int'(o_period_start), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("first_ps", int'(o_period_start), 1);

      foreach (vecs[i]) begin
         do_reset();
         repeat (3) @(negedge i_clk);
         strobe(vecs[i].top, vecs[i].cmp, 1'b1, 1'b1);
         wait_ps($sformatf("v%0d", i));
         measure(n, h);
         check($sformatf("v%0d_period", i), n, vecs[i].period);
         check($sformatf("v%0d_highs", i), h, vecs[i].highs);
      end

      // Exact waveform for top 3, compare 2
      do_reset();
      repeat (3) @(negedge i_clk);
      strobe(3, 2, 1'b1, 1'b1);
      wait_ps("pat");
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge i_clk);
         pat_pwm[7-k] = o_pwm;
         pat_ps[7-k]  = o_period_start;
      end
`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
      check("pat_pwm", int'(pat_pwm), 'hC7);
      check("pat_ps", int'(pat_ps), 'h82);
`else
      check("pat_pwm", int'(pat_pwm), 'hCC);
      check("pat_ps", int'(pat_ps), 'h88);
`endif

      // Compare 2 -> 3 mid-period: current period unchanged, next one updated
      do_reset();
      repeat (3) @(negedge i_clk);
      strobe(3, 2, 1'b1, 1'b1);
      wait_ps("mid");
      h = int'(o_pwm);
      n = 1;
      i_compare       = CW'(3);
      i_compare_valid = 1'b1;
      @(negedge i_clk);
      i_compare_valid = 1'b0;
      while (!o_period_start && n < 1200) begin
         h += int'(o_pwm);
         n++;
         @(negedge i_clk);
      end
`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
      check("mid_cur_highs", h, 3);
      measure(n, h);
      check("mid_next_highs", h, 5);
`else
      check("mid_cur_highs", h, 2);
      measure(n, h);
      check("mid_next_highs", h, 3);
`endif

      // Compare strobed exactly in the wrap cycle takes effect next period
      repeat (p - 2) @(negedge i_clk);
      strobe(3, 1, 1'b0, 1'b1);
      wait_ps("wrapld");
      measure(n, h);
      check("wrapld_highs", h, 1);
      measure(n, h);
      check("wrapld_after_highs", h, 1);

      // Reset mid-period with a pending compare
      do_reset();
      repeat (3) @(negedge i_clk);
      strobe(3, 2, 1'b1, 1'b1);
      wait_ps("rstmid");
      i_compare       = CW'(5);
      i_compare_valid = 1'b1;
      @(negedge i_clk);
      i_compare_valid = 1'b0;
      check("rstmid_pre_pwm", int'(o_pwm), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("rstmid_async_pwm", int'(o_pwm), 0);
      check("rstmid_async_ps", int'(o_period_start), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wait_ps("rstmid_rel");
      measure(n, h);
`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
      check("rstmid_p1_period", n, 510);
`else
      check("rstmid_p1_period", n, 256);
`endif
      check("rstmid_p1_highs", h, 0);
      measure(n, h);
`ifdef PWM_GENERATOR_PHASE_CORRECT_EN
      check("rstmid_p2_period", n, 510);
`else
      check("rstmid_p2_period", n, 256);
`endif
      check("rstmid_p2_highs", h, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
